seq_checker: RTL and testbench

Receive-side companion to the Padovan-style sequence generator (s[n] = s[n-2] + s[n-3] mod 2^32, canonical start 0,1,1). It sits on the consumer end of a 32-bit sequence link and does three things:
- self-synchronises to the incoming stream from any starting point;
- predicts each next sample and flags mismatches;
- reports lock status and a saturating error count for link/BIST monitoring.

---
 rtl/seq_checker.sv | 154 +++++++++++++++
 tb/tb_seq_checker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_checker.sv
// seq_checker: receive-side checker for a Padovan-style 32-bit sequence link
// (s[n] = s[n-2] + s[n-3] mod 2^32). It self-synchronises to the stream,
// predicts each next sample, flags mismatches, reports lock and counts errors.
module seq_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seq_valid_i,
  input  logic [31:0]      seq_i,
  output logic             locked_o,
  output logic             match_o,
  output logic             mismatch_o,
  output logic [ERR_W-1:0] err_count_o,
  output logic [31:0]      expected_o
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           r_state, w_state_n;
  logic [31:0]      r_h0, r_h1, r_h2;
  logic [31:0]      w_h0_n, w_h1_n, w_h2_n;
  logic [1:0]       r_fill, w_fill_n;
  logic [MW-1:0]    r_mcnt, w_mcnt_n, w_mcnt_inc;
  logic [LW-1:0]    r_miss, w_miss_n, w_miss_inc;
  logic [ERR_W-1:0] r_err, w_err_n;
  logic             r_match, w_match_n;
  logic             r_mismatch, w_mismatch_n;
  logic             r_locked, w_locked_n;
  logic [31:0]      r_exp, w_exp_n;
  logic [31:0]      w_pred;
  logic [31:0]      w_shift;

  assign locked_o    = r_locked;
  assign match_o     = r_match;
  assign mismatch_o  = r_mismatch;
  assign err_count_o = r_err;
  assign expected_o  = r_exp;

  // State and datapath registers; synchronous reset returns everything to FILL.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FILL;
      r_h0       <= '0;
      r_h1       <= '0;
      r_h2       <= '0;
      r_fill     <= '0;
      r_mcnt     <= '0;
      r_miss     <= '0;
      r_err      <= '0;
      r_match    <= 1'b0;
      r_mismatch <= 1'b0;
      r_locked   <= 1'b0;
      r_exp      <= '0;
    end else begin
      r_state    <= w_state_n;
      r_h0       <= w_h0_n;
      r_h1       <= w_h1_n;
      r_h2       <= w_h2_n;
      r_fill     <= w_fill_n;
      r_mcnt     <= w_mcnt_n;
      r_miss     <= w_miss_n;
      r_err      <= w_err_n;
      r_match    <= w_match_n;
      r_mismatch <= w_mismatch_n;
      r_locked   <= w_locked_n;
      r_exp      <= w_exp_n;
    end
  end

  // Next-state, history shift, counters and verdict pulses for one valid sample.
  always_comb begin
    w_state_n    = r_state;
    w_h0_n       = r_h0;
    w_h1_n       = r_h1;
    w_h2_n       = r_h2;
    w_fill_n     = r_fill;
    w_mcnt_n     = r_mcnt;
    w_miss_n     = r_miss;
    w_err_n      = r_err;
    w_match_n    = 1'b0;
    w_mismatch_n = 1'b0;
    w_exp_n      = r_exp;
    w_pred       = r_h0 + r_h1;
    w_shift      = seq_i;
    w_mcnt_inc   = r_mcnt + 1'b1;
    w_miss_inc   = r_miss + 1'b1;

    if (seq_valid_i) begin
      unique case (r_state)
        FILL: begin
          if (r_fill == 2'd2) begin
            w_state_n = ACQUIRE;
            w_fill_n  = '0;
            w_mcnt_n  = '0;
          end else begin
            w_fill_n = r_fill + 2'd1;
          end
        end
        ACQUIRE: begin
          if (seq_i == w_pred) begin
            w_match_n = 1'b1;
            if (w_mcnt_inc == MW'(LOCK_CNT)) begin
              w_state_n = LOCKED;
              w_mcnt_n  = '0;
              w_miss_n  = '0;
            end else begin
              w_mcnt_n = w_mcnt_inc;
            end
          end else begin
            w_mismatch_n = 1'b1;
            w_mcnt_n     = '0;
          end
        end
        LOCKED: begin
          if (seq_i == w_pred) begin
            w_match_n = 1'b1;
            w_miss_n  = '0;
          end else begin
            w_mismatch_n = 1'b1;
            w_err_n      = (r_err == '1) ? r_err : r_err + 1'b1;
            // Flywheel: bridge a corrupt sample with the prediction, except on
            // the miss that drops lock, where live data seeds re-acquisition.
            if (w_miss_inc == LW'(LOSS_CNT)) begin
              w_state_n = ACQUIRE;
              w_mcnt_n  = '0;
              w_miss_n  = '0;
            end else begin
              w_miss_n = w_miss_inc;
              w_shift  = w_pred;
            end
          end
        end
        default: w_state_n = FILL;
      endcase
      w_h0_n  = r_h1;
      w_h1_n  = r_h2;
      w_h2_n  = w_shift;
      w_exp_n = r_h1 + r_h2;
    end

    w_locked_n = (w_state_n == LOCKED);
  end

endmodule

// File: tb/tb_seq_checker.sv
// Testbench for seq_checker: directed scenarios plus randomized stream with
// corruption, invalid cycles and resets, checked through a scoreboard queue.
module tb_seq_checker;

  localparam int LOCK = 4;
  localparam int LOSS = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        seq_valid_i = 1'b0;
  logic [31:0] seq_i = '0;
  logic        locked_o, match_o, mismatch_o;
  logic [15:0] err_count_o;
  logic [31:0] expected_o;
  logic        locked2, match2, mismatch2;
  logic [1:0]  err2;
  logic [31:0] expected2;

  seq_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERR_W(16)) dut (
    .clk(clk), .reset(reset), .seq_valid_i(seq_valid_i), .seq_i(seq_i),
    .locked_o(locked_o), .match_o(match_o), .mismatch_o(mismatch_o),
    .err_count_o(err_count_o), .expected_o(expected_o)
  );

  seq_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .seq_valid_i(seq_valid_i), .seq_i(seq_i),
    .locked_o(locked2), .match_o(match2), .mismatch_o(mismatch2),
    .err_count_o(err2), .expected_o(expected2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          m;
    bit          mm;
    bit          lk;
    int          err;
    int          err2;
    bit [31:0]   exp;
    bit          chk_exp;
  } item_t;

  item_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  // Reference model: history of accepted samples as a queue, lock as a flag.
  bit [31:0] hist[$];
  bit        m_lk;
  int        m_mcnt, m_miss, m_err, m_err2;
  bit [31:0] m_exp;

  task automatic model_reset();
    hist.delete();
    m_lk = 0; m_mcnt = 0; m_miss = 0; m_err = 0; m_err2 = 0; m_exp = '0;
  endtask

  task automatic model_step(input bit [31:0] s, output bit hit, output bit bad);
    bit [31:0] pred, keep;
    hit = 0; bad = 0;
    if (hist.size() < 3) begin
      hist.push_back(s);
      if (hist.size() == 3) m_exp = hist[0] + hist[1];
      return;
    end
    pred = hist[0] + hist[1];
    keep = s;
    hit  = (s == pred);
    bad  = !hit;
    if (!m_lk) begin
      if (hit) begin
        m_mcnt++;
        if (m_mcnt == LOCK) begin m_lk = 1; m_miss = 0; m_mcnt = 0; end
      end else m_mcnt = 0;
    end else if (hit) begin
      m_miss = 0;
    end else begin
      if (m_err < 65535) m_err++;
      if (m_err2 < 3) m_err2++;
      m_miss++;
      if (m_miss == LOSS) begin m_lk = 0; m_mcnt = 0; m_miss = 0; end
      else keep = pred;
    end
    void'(hist.pop_front());
    hist.push_back(keep);
    m_exp = hist[0] + hist[1];
  endtask

  task automatic drive(input bit rst, input bit v, input bit [31:0] d);
    item_t it;
    bit hit, bad;
    reset = rst; seq_valid_i = v; seq_i = d;
    hit = 0; bad = 0;
    if (rst) model_reset();
    else if (v) model_step(d, hit, bad);
    it.cyc = cyc + 1; it.m = hit; it.mm = bad; it.lk = m_lk;
    it.err = m_err; it.err2 = m_err2; it.exp = m_exp;
    it.chk_exp = rst || (hist.size() == 3);
    sb.push_back(it);
    @(posedge clk); #1;
  endtask

  task automatic run_list(input bit [31:0] vals[$], input bit toggle);
    foreach (vals[i]) begin
      drive(0, 1, vals[i]);
      if (toggle) drive(0, 0, $urandom);
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops every expectation that has come due and compares both DUTs.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        it = sb.pop_front();
        chk("match_o", match_o, it.m);
        chk("mismatch_o", mismatch_o, it.mm);
        chk("locked_o", locked_o, it.lk);
        chk("err_count_o", err_count_o, it.err);
        chk("err_count_o_w2", err2, it.err2);
        chk("locked_o_w2", locked2, it.lk);
        if (it.chk_exp) begin
          chk("expected_o", expected_o, it.exp);
          chk("expected_o_w2", expected2, it.exp);
        end
      end
    end
  end

  initial begin
    bit [31:0] q[$];
    bit [31:0] a, b, c, v;
    int wait_cyc;

    // Basic lock on canonical stream, valid every cycle.
    drive(1, 0, '0);
    q = '{0, 1, 1, 1, 2, 2, 3, 4, 5, 7};
    run_list(q, 0);

    // Same stream, valid toggling with garbage on idle cycles.
    drive(1, 0, '0);
    run_list(q, 1);

    // Single corrupt sample while locked, then a burst that drops lock.
    drive(1, 0, '0);
    q = '{0, 1, 1, 1, 2, 2, 3, 40, 5, 7, 9, 100, 101, 102,
          21, 28, 37, 49, 65, 86, 114, 151};
    run_list(q, 0);

    // Mid-stream start, then wrap-around on 0x80000000 triples.
    drive(1, 0, '0);
    q = '{12, 16, 21, 28, 37, 49, 65};
    run_list(q, 0);
    drive(1, 0, '0);
    q = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0, 0, 32'h8000_0000};
    run_list(q, 0);

    // Five isolated errors while locked (saturates the 2-bit counter),
    // then reset overriding a valid sample.
    drive(1, 0, '0);
    q = '{0, 1, 1, 1, 2, 2, 3, 40, 5, 70, 9, 120, 16, 210, 28, 370, 49};
    run_list(q, 0);
    drive(1, 1, 32'hDEAD_BEEF);
    drive(0, 0, '0);

    // Randomized stream: idle cycles, corruption and occasional resets.
    a = $urandom; b = $urandom; c = $urandom;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) drive(1, $urandom_range(0, 1), $urandom);
      else if ($urandom_range(0, 3) == 0) drive(0, 0, $urandom);
      else begin
        v = a;
        {a, b, c} = {b, c, a + b};
        if ($urandom_range(0, 9) == 0) v = v ^ ($urandom | 32'd1);
        drive(0, 1, v);
      end
    end
    drive(0, 0, '0);

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(negedge clk); #1;
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
